// File: rtl/reg_32.sv
// reg_32 - 32-bit load-enabled word register with synchronous reset.
// The datapath uses it as its general-purpose word register. The register
// file and the program-counter and status registers are built from it.
//
// Ports (order kept for drop-in compatibility):
//   Q  [31:0] out  stored word, driven straight from the flops
//   D  [31:0] in   word captured on a rising edge of C when L=1
//   L         in   load enable, active-high
//   C         in   clock, rising edge only
//   nR        in   synchronous reset, active-high despite the name
//
// Next state at each rising edge of C, in priority order:
//   nR=1 -> 0; else L=1 -> D; else hold.

module reg_32 (
  output logic [31:0] Q,
  input  logic [31:0] D,
  input  logic        L,
  input  logic        C,
  input  logic        nR
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  // A 2:1 mux per bit. L selects the new word, otherwise the bit recirculates.
  always_comb begin
    q_d = q_q;
    if (L) begin
      q_d = D;
    end
  end

  // Reset forces every flop input to 0 and takes priority over load.
  always_ff @(posedge C) begin
    if (nR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_reg_32.sv
// Self-checking bench for reg_32. It uses a scoreboard queue of expected
// post-edge values and a reference model driven by random stimulus.

module tb_reg_32;

  logic [31:0] Q;
  logic [31:0] D;
  logic        L;
  logic        C;
  logic        nR;

  reg_32 dut (
    .Q  (Q),
    .D  (D),
    .L  (L),
    .C  (C),
    .nR (nR)
  );

  // 10-unit period: rising edges at 5, 15, 25 ... and falling edges at 10, 20 ...
  initial C = 1'b0;
  always #5 C = ~C;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned edge_no = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model;
  logic [31:0] last_exp;
  bit          have_exp = 0;

  // Monitor: compares Q to the oldest expected value just after each rising edge.
  initial begin
    forever begin
      @(posedge C);
      #1;
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        edge_no++;
        checks++;
        if (Q !== e) begin
          errors++;
          $display("FAIL edge%0d: Q=%h expected=%h", edge_no, Q, e);
        end
        last_exp = e;
        have_exp = 1;
      end
    end
  end

  // Just before each rising edge, after the inputs have changed, Q must still
  // hold the value from the previous edge.
  initial begin
    forever begin
      @(negedge C);
      #4;
      if (have_exp) begin
        checks++;
        if (Q !== last_exp) begin
          errors++;
          $display("FAIL pre_edge%0d: Q=%h expected=%h", edge_no, Q, last_exp);
        end
      end
    end
  end

  // Drive one cycle's inputs on the falling edge and push the expected result.
  // With glitch set, L and D are toggled between edges before settling.
  task automatic step(input logic nr, input logic l, input logic [31:0] d,
                      input bit glitch);
    @(negedge C);
    if (glitch) begin
      L = 1'b1;
      D = $urandom;
      #1;
      D = $urandom;
      L = 1'b0;
      #1;
    end
    nR = nr;
    L  = l;
    D  = d;
    if (nr)     model = 32'h0000_0000;
    else if (l) model = d;
    exp_q.push_back(model);
  endtask

  initial begin
    nR = 1'b0;
    L  = 1'b0;
    D  = '0;
    model = 'x;

    // Directed sequence taken from the behavioural description.
    step(1'b1, 1'b1, 32'd5, 0);          // reset overrides load
    step(1'b0, 1'b1, 32'd2, 0);          // load 2
    step(1'b0, 1'b0, 32'd3, 0);          // hold
    step(1'b0, 1'b0, 32'd3, 0);          // hold
    step(1'b1, 1'b0, 32'd3, 0);          // mid-operation reset
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 0);  // all ones
    step(1'b0, 1'b1, 32'hA5A5_5A5A, 0);  // alternating pattern
    step(1'b0, 1'b0, 32'h1234_5678, 1);  // glitch on L and D, then hold
    step(1'b0, 1'b0, 32'h0000_0000, 1);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 0);  // reset while holding data
    step(1'b0, 1'b1, 32'h0000_0001, 0);
    step(1'b0, 1'b1, 32'h8000_0000, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r_nr;
      logic        r_l;
      logic [31:0] r_d;
      bit          r_g;
      r_nr = ($urandom_range(15) == 0);
      r_l  = $urandom_range(1);
      case ($urandom_range(7))
        0:       r_d = 32'hFFFF_FFFF;
        1:       r_d = 32'h0000_0000;
        default: r_d = $urandom;
      endcase
      r_g = (!r_l) && ($urandom_range(3) == 0);
      step(r_nr, r_l, r_d, r_g);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge C);
      #2;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
